// File: rtl/drive_source_arbiter.sv
// rtl/drive_source_arbiter.sv - grants the car's motion inputs to manual, semi-auto or auto with a forced stop window
// Optional MOTION_ARB_REVERSE_EN lets the manual source drive move_backward_signal.
module drive_source_arbiter #(
  parameter int STOP_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic [1:0] mode,
  input  logic       man_fwd,
  input  logic       man_back,
  input  logic       man_left,
  input  logic       man_right,
  input  logic       semi_fwd,
  input  logic       semi_left,
  input  logic       semi_right,
  input  logic       auto_fwd,
  input  logic       auto_left,
  input  logic       auto_right,
  output logic       move_forward_signal,
  output logic       move_backward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic [1:0] active_mode,
  output logic [1:0] state,
  output logic       switching
);

  localparam int CW = $clog2(STOP_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STOP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STOP = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t        cur_state;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_prev;

  logic sel_fwd, sel_back, sel_left, sel_right;
  logic nxt_fwd, nxt_back, nxt_left, nxt_right;

  always_comb begin
    sel_fwd   = 1'b0;
    sel_back  = 1'b0;
    sel_left  = 1'b0;
    sel_right = 1'b0;
    case (active_mode)
      2'b00: begin
        sel_fwd   = man_fwd;
        sel_left  = man_left;
        sel_right = man_right;
`ifdef MOTION_ARB_REVERSE_EN
        sel_back  = man_back;
`endif
      end
      2'b01: begin
        sel_fwd   = semi_fwd;
        sel_left  = semi_left;
        sel_right = semi_right;
      end
      2'b10: begin
        sel_fwd   = auto_fwd;
        sel_left  = auto_left;
        sel_right = auto_right;
      end
      default: ;
    endcase
  end

`ifndef MOTION_ARB_REVERSE_EN
  logic unused_man_back;
  assign unused_man_back = man_back;
`endif

  // Opposing requests cancel each other rather than picking a winner.
  assign nxt_fwd   = sel_fwd & ~sel_back;
  assign nxt_back  = sel_back & ~sel_fwd;
  assign nxt_left  = sel_left & ~sel_right;
  assign nxt_right = sel_right & ~sel_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state            <= IDLE;
      cnt                  <= '0;
      mode_prev            <= 2'b00;
      active_mode          <= 2'b00;
      switching            <= 1'b0;
      move_forward_signal  <= 1'b0;
      move_backward_signal <= 1'b0;
      turn_left_signal     <= 1'b0;
      turn_right_signal    <= 1'b0;
    end else if (!power_on) begin
      cur_state            <= IDLE;
      cnt                  <= '0;
      switching            <= 1'b0;
      move_forward_signal  <= 1'b0;
      move_backward_signal <= 1'b0;
      turn_left_signal     <= 1'b0;
      turn_right_signal    <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          cur_state <= STOP;
          cnt       <= RELOAD;
          mode_prev <= mode;
          switching <= 1'b1;
        end
        STOP: begin
          mode_prev            <= mode;
          move_forward_signal  <= 1'b0;
          move_backward_signal <= 1'b0;
          turn_left_signal     <= 1'b0;
          turn_right_signal    <= 1'b0;
          // A valid mode arriving after an expired window spent on 11 is granted immediately.
          if (cnt == '0 && mode != 2'b11 && (mode == mode_prev || mode_prev == 2'b11)) begin
            cur_state   <= RUN;
            active_mode <= mode;
            switching   <= 1'b0;
          end else if (mode != mode_prev) begin
            cnt <= RELOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (mode != active_mode) begin
            cur_state            <= STOP;
            cnt                  <= RELOAD;
            mode_prev            <= mode;
            switching            <= 1'b1;
            move_forward_signal  <= 1'b0;
            move_backward_signal <= 1'b0;
            turn_left_signal     <= 1'b0;
            turn_right_signal    <= 1'b0;
          end else begin
            move_forward_signal  <= nxt_fwd;
            move_backward_signal <= nxt_back;
            turn_left_signal     <= nxt_left;
            turn_right_signal    <= nxt_right;
          end
        end
        default: begin
          cur_state <= IDLE;
          switching <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: doc/drive_source_arbiter.md
# drive_source_arbiter

Arbiter and sequencer that owns the simulated car's motion inputs (forward, backward, turn left, turn right) and grants them to exactly one of three requesters: manual user buttons, the semi-auto driving FSM, or the auto driving FSM. On power-up and on every mode change it forces a stop window with all motion signals low before the new source is granted. It sits between the driving-mode controllers and the UART-linked simulated device in the top level.

## Interface
- STOP_CYCLES, 10_000_000, length of the forced stop window in clk cycles (100 ms at 100 MHz); legal range 1..2^26-1
- clk  in  1  system clock (100 MHz board clock)
- rst  in  1  synchronous, active-high reset
- power_on  in  1  level; 0 forces IDLE with all motion outputs low
- mode  in  2  requested source: 00 manual, 01 semi-auto, 10 auto, 11 invalid
- man_fwd, man_back, man_left, man_right  in  1 each  manual requests (levels)
- semi_fwd, semi_left, semi_right  in  1 each  semi-auto requests
- auto_fwd, auto_left, auto_right  in  1 each  auto requests
- move_forward_signal, move_backward_signal, turn_left_signal, turn_right_signal  out  1 each  registered motion outputs to the simulated device
- active_mode  out  2  source currently granted (valid in RUN; holds last granted value otherwise)
- state  out  2  00 IDLE, 01 STOP, 10 RUN
- switching  out  1  high while in STOP

## Operation
- States: IDLE, STOP, RUN; stop counter cnt, width clog2(STOP_CYCLES+1).
- IDLE: all motion outputs 0. power_on=1 -> STOP, cnt loaded with STOP_CYCLES-1.
- STOP: motion outputs 0, switching=1. cnt decrements each cycle. mode sampled each cycle; if mode differs from the value sampled the previous cycle, cnt reloads to STOP_CYCLES-1. When cnt==0 and mode!=11 -> RUN, active_mode<=mode. When cnt==0 and mode==11 -> stay in STOP with cnt held at 0 until a valid mode appears, then RUN next cycle.
- RUN: outputs are registered copies of the granted source's requests. If mode!=active_mode (including 11) -> STOP with cnt reload; outputs 0 from that transition onward.
- power_on=0 in any state -> IDLE next cycle; overrides every other transition.
- Conflict rules, applied to the granted source before registering: fwd&back both 1 -> both outputs 0; left&right both 1 -> both outputs 0. Forward/backward and turns are otherwise independent.
- Semi-auto and auto sources have no backward request; move_backward_signal is 0 unless granted source is manual (see Configuration).
- Non-granted sources are ignored entirely.

## Timing
- Reset: state=IDLE, active_mode=00, cnt=0, switching=0, all motion outputs 0.
- RUN latency: request input to motion output = 1 cycle.
- Mode change in RUN at cycle N: outputs 0 from N+1; earliest new-source output at N+1+STOP_CYCLES+1 (STOP lasts exactly STOP_CYCLES cycles, then 1-cycle registered latency).
- power_on rising at cycle N from IDLE: STOP from N+1, RUN from N+1+STOP_CYCLES.
- rst mid-STOP or mid-RUN: reset values on next edge; power_on still high -> normal startup stop window follows.
- STOP_CYCLES=1: STOP lasts one cycle.

## Configuration
- MOTION_ARB_REVERSE_EN defined: when manual is granted, man_back drives move_backward_signal (subject to fwd/back conflict rule).
- Not defined: man_back ignored, move_backward_signal constant 0, fwd/back conflict rule reduces to pass-through of man_fwd.

## Test plan
- STOP_CYCLES=4; rst, then power_on=1, mode=00, man_fwd=1 -> state STOP for 4 cycles, then RUN, move_forward_signal=1 one cycle after RUN entry; all outputs 0 before.
- In RUN manual, switch mode to 01 with semi_left=1, man_fwd=1 -> outputs 0 for 4 cycles, switching=1, then turn_left_signal=1, move_forward_signal=0, active_mode=01.
- In STOP, toggle mode 01->10 at cnt=1 -> cnt reloads, RUN entered 4 cycles after last change with active_mode=10.
- mode=11 in RUN -> STOP, outputs 0, stays in STOP indefinitely; mode=10 -> RUN next cycle.
- Granted manual with man_left=man_right=1, then with REVERSE_EN man_fwd=man_back=1 -> respective output pairs both 0; man_back alone -> move_backward_signal=1 (0 without macro).
- power_on dropped mid-RUN with auto_fwd=1 -> next cycle state IDLE, all outputs 0; rst asserted mid-STOP -> reset values next edge.
